// File: rtl/xor_arb_pkg.sv
// Shared types and defaults for the two-requester XOR arbiter.
// Latency: n/a (types, constants and a pure helper function only).
// Backpressure: n/a.
//
// Contents:
//   WIDTH_DEF / CNT_W_DEF : default operand width and op counter width
//   state_t               : FSM encoding IDLE=0, EXEC=1, DONE=2
//   REQ_0 / REQ_1         : requester identifiers as stored in the pointer
//   pick_winner()         : round-robin choice between the two requesters
package xor_arb_pkg;

  localparam int WIDTH_DEF = 8;
  localparam int CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic REQ_0 = 1'b0;
  localparam logic REQ_1 = 1'b1;

  // On a tie the requester that was not served last wins; a lone
  // requester wins regardless of the pointer. Only meaningful when at
  // least one request is present.
  function automatic logic pick_winner(input logic r0,
                                       input logic r1,
                                       input logic last_served);
    logic win;
    if (r0 && r1) begin
      win = ~last_served;
    end else if (r0) begin
      win = REQ_0;
    end else begin
      win = REQ_1;
    end
    return win;
  endfunction

endpackage

// File: rtl/xor_unit.sv
// Combinational WIDTH-bit bitwise XOR datapath.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows the inputs.
//
// Ports:
//   a, b : operands
//   y    : a ^ b, full width, no carry or sign handling
module xor_unit #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = a ^ b;

endmodule

// File: rtl/xor_arbiter.sv
// Two-requester round-robin arbiter feeding one shared registered XOR unit.
// Latency: gnt one edge after req is sampled, done/result two edges after; one op per 3 cycles.
// Backpressure: req is sampled only in IDLE; requests during EXEC/DONE wait for the next IDLE.
//
// Ports:
//   clk, reset          : single clock, synchronous active-high reset
//   req0/req1           : level requests; drop them in the cycle gnt is seen
//   a0,b0 / a1,b1       : operands, latched on the edge that raises gnt
//   gnt0/gnt1           : one-cycle grant pulse to the winner
//   done0/done1         : one-cycle completion pulse to the winner
//   result              : registered a^b of the last served request
//   busy                : high whenever the FSM is not in IDLE
//   op_count            : completed operations, wraps silently
module xor_arbiter
  import xor_arb_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  state_t           state_q;
  logic             win_q;    // requester being served in EXEC/DONE
  logic             last_q;   // requester served most recently
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  logic             winner_c;
  logic [WIDTH-1:0] a_sel;
  logic [WIDTH-1:0] b_sel;
  logic [WIDTH-1:0] xor_y;

  // Winner and its operands are resolved combinationally so they can be
  // captured on the same edge that samples the requests.
  always_comb begin
    winner_c = pick_winner(req0, req1, last_q);
    a_sel    = (winner_c == REQ_1) ? a1 : a0;
    b_sel    = (winner_c == REQ_1) ? b1 : b0;
  end

  // Operates on the latched copies only, so operand changes after the
  // grant edge cannot leak into result.
  xor_unit #(
    .WIDTH (WIDTH)
  ) u_xor (
    .a (a_q),
    .b (b_q),
    .y (xor_y)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      win_q    <= REQ_0;
      // Pointer parks on requester 1 so requester 0 takes the first tie.
      last_q   <= REQ_1;
      a_q      <= '0;
      b_q      <= '0;
      gnt0     <= 1'b0;
      gnt1     <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      result   <= '0;
      busy     <= 1'b0;
      op_count <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done0 <= 1'b0;
          done1 <= 1'b0;
          if (req0 || req1) begin
            state_q <= EXEC;
            busy    <= 1'b1;
            win_q   <= winner_c;
            a_q     <= a_sel;
            b_q     <= b_sel;
            gnt0    <= (winner_c == REQ_0);
            gnt1    <= (winner_c == REQ_1);
          end else begin
            gnt0 <= 1'b0;
            gnt1 <= 1'b0;
          end
        end

        EXEC: begin
          gnt0    <= 1'b0;
          gnt1    <= 1'b0;
          result  <= xor_y;
          done0   <= (win_q == REQ_0);
          done1   <= (win_q == REQ_1);
          state_q <= DONE;
        end

        DONE: begin
          done0    <= 1'b0;
          done1    <= 1'b0;
          op_count <= op_count + CNT_W'(1);
          last_q   <= win_q;
          busy     <= 1'b0;
          state_q  <= IDLE;
        end

        default: begin
          // Unreachable encoding: fall back to a quiet IDLE.
          gnt0    <= 1'b0;
          gnt1    <= 1'b0;
          done0   <= 1'b0;
          done1   <= 1'b0;
          busy    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xor_arbiter.sv
module tb_xor_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req0, req1;
  logic [7:0] a0, b0, a1, b1;

  logic        gnt0, gnt1, done0, done1, busy;
  logic [7:0]  result;
  logic [15:0] op_count;

  logic        gnt0_w, gnt1_w, done0_w, done1_w, busy_w;
  logic [7:0]  result_w;
  logic [3:0]  op_count_w;

  int n_asrt = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  xor_arbiter dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .result(result), .busy(busy), .op_count(op_count)
  );

  xor_arbiter #(.WIDTH(8), .CNT_W(4)) dut_w (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0_w), .gnt1(gnt1_w), .done0(done0_w), .done1(done1_w),
    .result(result_w), .busy(busy_w), .op_count(op_count_w)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic g0, input logic g1,
                         input logic d0, input logic d1, input logic bz);
    chk({tag, ".gnt0"},  32'(gnt0),  32'(g0));
    chk({tag, ".gnt1"},  32'(gnt1),  32'(g1));
    chk({tag, ".done0"}, 32'(done0), 32'(d0));
    chk({tag, ".done1"}, 32'(done1), 32'(d1));
    chk({tag, ".busy"},  32'(busy),  32'(bz));
    chk({tag, ".w.gnt0"},  32'(gnt0_w),  32'(g0));
    chk({tag, ".w.gnt1"},  32'(gnt1_w),  32'(g1));
    chk({tag, ".w.done0"}, 32'(done0_w), 32'(d0));
    chk({tag, ".w.done1"}, 32'(done1_w), 32'(d1));
    chk({tag, ".w.busy"},  32'(busy_w),  32'(bz));
  endtask

  task automatic chk_res(input string tag, input logic [7:0] exp);
    chk({tag, ".result"},   32'(result),   32'(exp));
    chk({tag, ".w.result"}, 32'(result_w), 32'(exp));
  endtask

  task automatic chk_cnt(input string tag, input int exp);
    chk({tag, ".op_count"},   32'(op_count),   32'(exp) & 32'h0000_FFFF);
    chk({tag, ".w.op_count"}, 32'(op_count_w), 32'(exp) & 32'h0000_000F);
  endtask

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = 8'h00; b0 = 8'h00; a1 = 8'h00; b1 = 8'h00;

    // Reset held two cycles, then idle with no requests.
    tick; tick;
    chk_ctl("reset", 0, 0, 0, 0, 0);
    chk_res("reset", 8'h00);
    chk_cnt("reset", 0);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      chk_ctl("idle", 0, 0, 0, 0, 0);
      chk_res("idle", 8'h00);
      chk_cnt("idle", 0);
    end

    // Single request from requester 0; operands change after the latch edge.
    req0 = 1'b1; a0 = 8'hA5; b0 = 8'h0F;
    tick;
    chk_ctl("single.gnt", 1, 0, 0, 0, 1);
    req0 = 1'b0; a0 = 8'h00; b0 = 8'hFF;
    tick;
    chk_ctl("single.done", 0, 0, 1, 0, 1);
    chk_res("single.done", 8'hAA);
    chk_cnt("single.done", 0);
    tick;
    chk_ctl("single.back", 0, 0, 0, 0, 0);
    chk_res("single.back", 8'hAA);
    chk_cnt("single.back", 1);

    // req1 raised during EXEC is ignored until the next IDLE.
    req0 = 1'b1; a0 = 8'h11; b0 = 8'h22;
    tick;
    chk_ctl("busy.gnt0", 1, 0, 0, 0, 1);
    req0 = 1'b0; req1 = 1'b1; a1 = 8'h12; b1 = 8'h34;
    tick;
    chk_ctl("busy.exec", 0, 0, 1, 0, 1);
    chk_res("busy.exec", 8'h33);
    tick;
    chk_ctl("busy.donest", 0, 0, 0, 0, 0);
    chk_cnt("busy.donest", 2);
    tick;
    chk_ctl("busy.gnt1", 0, 1, 0, 0, 1);
    req1 = 1'b0;
    tick;
    chk_ctl("busy.done1", 0, 0, 0, 1, 1);
    chk_res("busy.done1", 8'h26);
    tick;
    chk_ctl("busy.end", 0, 0, 0, 0, 0);
    chk_cnt("busy.end", 3);

    // Both requesters held for 12 cycles: round-robin 0,1,0,1.
    reset = 1'b1;
    tick;
    reset = 1'b0;
    chk_cnt("rr.reset", 0);
    a0 = 8'hFF; b0 = 8'h00; a1 = 8'h3C; b1 = 8'h3C;
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk_ctl("rr.gnt", (i % 2) == 0, (i % 2) == 1, 0, 0, 1);
      tick;
      chk_ctl("rr.done", 0, 0, (i % 2) == 0, (i % 2) == 1, 1);
      chk_res("rr.done", ((i % 2) == 0) ? 8'hFF : 8'h00);
      tick;
      chk_ctl("rr.idle", 0, 0, 0, 0, 0);
      chk_cnt("rr.idle", i + 1);
    end
    req0 = 1'b0; req1 = 1'b0;

    // Reset in the EXEC cycle aborts the operation and re-arms the pointer.
    reset = 1'b1;
    tick;
    reset = 1'b0;
    req0 = 1'b1; a0 = 8'h55; b0 = 8'hAA;
    tick;
    chk_ctl("abort.gnt", 1, 0, 0, 0, 1);
    reset = 1'b1; req0 = 1'b0;
    tick;
    chk_ctl("abort.rst", 0, 0, 0, 0, 0);
    chk_res("abort.rst", 8'h00);
    chk_cnt("abort.rst", 0);
    reset = 1'b0;
    tick;
    chk_ctl("abort.after", 0, 0, 0, 0, 0);
    chk_res("abort.after", 8'h00);
    chk_cnt("abort.after", 0);
    req0 = 1'b1; req1 = 1'b1;
    tick;
    chk_ctl("abort.tie", 1, 0, 0, 0, 1);
    req0 = 1'b0; req1 = 1'b0;
    tick;
    chk_ctl("abort.tiedone", 0, 0, 1, 0, 1);
    chk_res("abort.tiedone", 8'hFF);
    tick;
    chk_cnt("abort.tieend", 1);

    // Sixteen operations: the 4-bit counter wraps to 0, the 16-bit reads 16.
    reset = 1'b1;
    tick;
    reset = 1'b0;
    b0 = 8'hF0;
    for (int i = 0; i < 16; i++) begin
      req0 = 1'b1; a0 = 8'(i);
      tick;
      chk_ctl("wrap.gnt", 1, 0, 0, 0, 1);
      req0 = 1'b0;
      tick;
      chk_ctl("wrap.done", 0, 0, 1, 0, 1);
      chk_res("wrap.done", 8'(i) ^ 8'hF0);
      tick;
      chk_cnt("wrap.cnt", i + 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule

// File: doc/xor_arbiter.md
XOR_ARBITER -- requirements
Module: xor_arbiter

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result bit width.
REQ-002 Parameter: CNT_W, default 16, completed-operation counter width.
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  synchronous, active-high reset.
REQ-005 Port: req0 / req1  input  1 each  request from requester 0 / 1, level-sensitive.
REQ-006 Port: a0, b0 / a1, b1  input  WIDTH each  operands of requester 0 / 1.
REQ-007 Port: gnt0 / gnt1  output  1 each  one-cycle grant pulse; operands were latched on the edge that raised it.
REQ-008 Port: done0 / done1  output  1 each  one-cycle completion pulse to the granted requester.
REQ-009 Port: result  output  WIDTH  registered a^b of the last served request; held until the next completion.
REQ-010 Port: busy  output  1  high whenever state is not IDLE.
REQ-011 Port: op_count  output  CNT_W  number of completed operations.

Function
REQ-012 FSM states SHALL be IDLE, EXEC and DONE; every output SHALL be registered.
REQ-013 IDLE with no request: remain IDLE, with gnt0/gnt1/done0/done1 low.
REQ-014 IDLE with any request at edge k: latch the winner's operands, go to EXEC, and drive the winner's gnt high for exactly cycle k+1.
REQ-015 EXEC at edge k+1: result <= latched_a ^ latched_b, go to DONE, and drive the winner's done high for exactly cycle k+2.
REQ-016 DONE at edge k+2: op_count increments, state returns to IDLE, and the last-winner pointer updates to the served requester.
REQ-017 Latency from request sampled to done SHALL be 2 edges; throughput SHALL be 1 operation per 3 cycles.
REQ-018 Arbitration SHALL be round-robin: on a simultaneous req0 and req1, the requester not served last wins; with a single requester, that requester wins regardless of the pointer.
REQ-019 req0/req1 SHALL be sampled only in IDLE; requests arriving during EXEC or DONE are ignored until the next IDLE.
REQ-020 A requester still asserting req when the FSM is back in IDLE constitutes a new request; requesters deassert req in the cycle gnt is seen.
REQ-021 Operand changes after the latch edge SHALL NOT affect result.
REQ-022 gnt0 and gnt1 SHALL never be high together; the same holds for done0 and done1.
REQ-023 op_count SHALL wrap from all-ones to 0 without any other effect.
REQ-024 result SHALL be full-width bitwise XOR with no carry, sign or truncation.

Reset
REQ-025 Reset high at an edge SHALL force state IDLE, gnt*/done*/busy = 0, result = 0, op_count = 0 and pointer = requester 1, so that requester 0 wins the first tie.
REQ-026 Reset asserted during EXEC or DONE SHALL abort the operation: no done pulse and no counter increment.
REQ-027 Reset SHALL have priority over every other transition in the same cycle.

Structure
REQ-028 Shared package xor_arb_pkg SHALL hold the state encoding (IDLE = 0, EXEC = 1, DONE = 2, 2 bits) and the WIDTH and CNT_W defaults.
REQ-029 Sub-module xor_unit (combinational WIDTH-bit a^b) SHALL be instantiated once; the arbiter registers its output into result.
REQ-030 Verification SHALL use a single top-level bench, tb_xor_arbiter.

Verification
REQ-031 Reset held 2 cycles, then released with no requests -> outputs all 0, busy 0 and op_count 0 for 5 cycles.
REQ-032 req0 with a0=8'hA5, b0=8'h0F -> gnt0 at k+1, done0 at k+2, result 8'hAA and op_count 1.
REQ-033 req0 and req1 high together, held 12 cycles, with a0=8'hFF, b0=8'h00, a1=8'h3C, b1=8'h3C -> grant order 0,1,0,1; results FF,00,FF,00; op_count 4.
REQ-034 req1 asserted while busy (during EXEC) -> no gnt1 until IDLE; gnt1 in the cycle after IDLE samples it.
REQ-035 Reset pulsed in the EXEC cycle -> no done pulse, op_count unchanged at 0, result 0.
REQ-036 op_count forced near wrap (CNT_W=4, 16 operations) -> op_count reads 0 after the 16th done.
